// File: rtl/my_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : my_arith_pkg
//  Description : Shared widths, FSM state encoding and step constant for the
//                sequential arithmetic units (my_mul16 and its adder).
//  Contents    : WORD_W, PROD_W, COUNT_W, state_t, LAST_STEP
//  Revision    : 1.0 - initial release
// ============================================================================
package my_arith_pkg;

    localparam int WORD_W  = 16;
    localparam int PROD_W  = 32;
    localparam int COUNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index of the final shift-add step; 16 steps in total (0..15).
    localparam logic [COUNT_W-1:0] LAST_STEP = COUNT_W'(15);

endpackage : my_arith_pkg
`default_nettype wire

// File: rtl/my_add16.sv
`default_nettype none
// ============================================================================
//  Module      : my_add16
//  Description : 16-bit combinational adder, carry-out discarded.
//  Ports       : a   [15:0] in  - addend
//                b   [15:0] in  - addend
//                sum [15:0] out - a + b modulo 2^16
//  Revision    : 1.0 - initial release
// ============================================================================
module my_add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    assign sum = a + b;

endmodule : my_add16
`default_nettype wire

// File: rtl/my_add17.sv
`default_nettype none
// ============================================================================
//  Module      : my_add17
//  Description : Wraps my_add16 and recovers the carry-out as a 17th sum bit.
//  Ports       : a   [15:0] in  - addend
//                b   [15:0] in  - addend
//                sum [16:0] out - full unsigned a + b
//  Revision    : 1.0 - initial release
// ============================================================================
module my_add17 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [16:0] sum
);

    logic [15:0] w_sum16;
    logic        w_carry;

    my_add16 u_add16 (
        .a   (a),
        .b   (b),
        .sum (w_sum16)
    );

    // Carry out of the MSB: both tops set, or exactly one set and the
    // resulting top sum bit wrapped to zero.
    assign w_carry = (a[15] & b[15]) | ((a[15] ^ b[15]) & ~w_sum16[15]);
    assign sum     = {w_carry, w_sum16};

endmodule : my_add17
`default_nettype wire

// File: rtl/my_mul16.sv
`default_nettype none
// ============================================================================
//  Module      : my_mul16
//  Description : Multi-cycle 16x16 -> 32-bit unsigned shift-add multiplier
//                with valid/ready handshakes, one operation in flight.
//  Ports       : clk          in      - rising-edge clock
//                rst_n        in      - synchronous active-low reset
//                in_valid     in      - operand pair offered
//                in_ready     out     - operands accepted (IDLE only)
//                in_a   [15:0] in     - multiplicand
//                in_b   [15:0] in     - multiplier
//                out_valid    out     - product available
//                out_ready    in      - consumer accepts product
//                out_product [31:0] out - unsigned in_a * in_b
//                out_busy     out     - high in RUN or DONE
//  Options     : MY_MUL16_ZERO_BYPASS_EN - zero operand skips the RUN phase
//  Revision    : 1.0 - initial release
// ============================================================================
module my_mul16
    import my_arith_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 out_busy
);

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    // Upper accumulator half. The 17th bit of the architectural acc_hi is
    // always zero after the right shift, so only 16 bits are stored.
    logic [WIDTH-1:0]     r_acc_hi;
    logic [WIDTH-1:0]     r_acc_lo;
    logic [COUNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;

    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum17;

    assign w_addend = r_acc_lo[0] ? r_mcand : '0;

    my_add17 u_add17 (
        .a   (r_acc_hi),
        .b   (w_addend),
        .sum (w_sum17)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mcand     <= '0;
            r_acc_hi    <= '0;
            r_acc_lo    <= '0;
            r_count     <= '0;
            r_product   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_mcand    <= in_a;
                        r_acc_hi   <= '0;
                        r_acc_lo   <= in_b;
                        r_count    <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef MY_MUL16_ZERO_BYPASS_EN
                        if ((in_a == '0) || (in_b == '0)) begin
                            // out_valid is raised on the following edge by
                            // the DONE state.
                            r_state   <= DONE;
                            r_product <= '0;
                        end else begin
                            r_state <= RUN;
                        end
`else
                        r_state <= RUN;
`endif
                    end
                end

                RUN: begin
                    // {acc_hi, acc_lo} <= {sum17, acc_lo} >> 1
                    r_acc_hi <= w_sum17[WIDTH:1];
                    r_acc_lo <= {w_sum17[0], r_acc_lo[WIDTH-1:1]};
                    r_count  <= r_count + COUNT_W'(1);
                    if (r_count == LAST_STEP) begin
                        r_state     <= DONE;
                        r_product   <= {w_sum17, r_acc_lo[WIDTH-1:1]};
                        r_out_valid <= 1'b1;
                    end
                end

                DONE: begin
                    // Entry without out_valid only happens via the zero
                    // bypass; raise it one cycle after acceptance.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_product = r_product;
    assign out_busy    = r_busy;

endmodule : my_mul16
`default_nettype wire

// File: tb/tb_my_mul16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_my_mul16
//  Description : Self-checking bench for my_mul16: vector table of products
//                plus handshake, backpressure, reset and back-to-back cases.
//  Options     : MY_MUL16_ZERO_BYPASS_EN - zero-operand latency becomes 1
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_my_mul16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_product;
    logic        out_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

`ifdef MY_MUL16_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 16;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    my_mul16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_busy    (out_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid; returns the number of edges waited (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Full operation with out_ready=1; called at a sample point in IDLE.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input int lat, input string nm);
        int n;
        check({nm, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a = 16'hDEAD; in_b = 16'hBEEF;  // must have no effect now
        check({nm, "_in_ready_drop"}, 32'(in_ready), 32'd0);
        wait_valid(n);
        check({nm, "_latency"}, 32'(n), 32'(lat));
        check({nm, "_product"}, out_product, exp);
        check({nm, "_busy"}, 32'(out_busy), 32'd1);
        tick();
        check({nm, "_valid_clr"}, 32'(out_valid), 32'd0);
        check({nm, "_back_idle"}, 32'(in_ready), 32'd1);
        check({nm, "_prod_keep"}, out_product, exp);
    endtask

    initial begin
        int n;
        int acc_cyc [3];
        logic [15:0] bb_a [3];
        logic [15:0] bb_b [3];
        logic [31:0] bb_p [3];

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, 16};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16};
        vecs[2] = '{16'h8000, 16'h0002, 32'h00010000, 16};
        vecs[3] = '{16'h1234, 16'h5678, 32'h06260060, 16};
        vecs[4] = '{16'h0001, 16'h0001, 32'h00000001, 16};
        vecs[5] = '{16'hFFFF, 16'h0001, 32'h0000FFFF, 16};
        vecs[6] = '{16'h00FF, 16'h0100, 32'h0000FF00, 16};
        vecs[7] = '{16'h0007, 16'h0009, 32'h0000003F, 16};
        vecs[8] = '{16'h0000, 16'hABCD, 32'h00000000, ZERO_LAT};
        vecs[9] = '{16'hABCD, 16'h0000, 32'h00000000, ZERO_LAT};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", out_product, 32'd0);
        check("rst_busy", 32'(out_busy), 32'd0);

        for (int i = 0; i < 10; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat, $sformatf("vec%0d", i));

        // Backpressure: product held, new offers ignored.
        in_a = 16'd3; in_b = 16'd5; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_valid(n);
        check("bp_latency", 32'(n), 32'd16);
        in_a = 16'h0011; in_b = 16'h0022; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid_hold", 32'(out_valid), 32'd1);
            check("bp_product_hold", out_product, 32'h0000000F);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_idle", 32'(in_ready), 32'd1);
        tick();
        check("bp_no_ghost_accept", 32'(in_ready), 32'd1);

        // Reset in the middle of RUN.
        in_a = 16'd7; in_b = 16'd9; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("mid_busy", 32'(out_busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_product", out_product, 32'd0);
        check("mid_rst_busy", 32'(out_busy), 32'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid) check("mid_rst_no_output", 32'(out_valid), 32'd0);
        end
        do_op(16'd2, 16'd2, 32'd4, 16, "post_rst");

        // Back-to-back with in_valid held high.
        bb_a[0] = 16'h0010; bb_b[0] = 16'h0020; bb_p[0] = 32'h00000200;
        bb_a[1] = 16'h00FF; bb_b[1] = 16'h00FF; bb_p[1] = 32'h0000FE01;
        bb_a[2] = 16'hC000; bb_b[2] = 16'h0004; bb_p[2] = 32'h00030000;
        out_ready = 1'b1;
        in_a = bb_a[0]; in_b = bb_b[0]; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!in_ready && n < 40) begin
                tick();
                n++;
            end
            check("b2b_ready_seen", 32'(in_ready), 32'd1);
            tick();
            acc_cyc[i] = cyc;
            if (i < 2) begin
                in_a = bb_a[i+1]; in_b = bb_b[i+1];
            end else begin
                in_valid = 1'b0;
            end
            wait_valid(n);
            check($sformatf("b2b%0d_product", i), out_product, bb_p[i]);
            if (i > 0)
                check($sformatf("b2b%0d_spacing", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd18);
        end
        tick();
        check("b2b_final_idle", 32'(in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_my_mul16
`default_nettype wire
